ili9341_init_seq: RTL and testbench

Parametrised power-up sequencer for the ILI9341 TFT controller on the PYNQ display path. It drives the hardware reset pulse, then walks an external command ROM and issues each command or data byte over a write-only 4-wire SPI link (CS, D/C, SCLK, MOSI). It also honours in-ROM delay entries and reports completion. It sits between the board reset/start logic and the pixel streamer, which may only take the SPI bus once `done` is high.

---
 rtl/ili9341_pkg.sv | 43 ++++
 rtl/spi_tx_byte.sv | 87 ++++++++
 rtl/ili9341_init_seq.sv | 169 ++++++++++++++++
 tb/tb_ili9341_init_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 power-up sequencer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package ili9341_pkg;

    // Two-bit type field at the top of every ROM word.
    typedef enum logic [1:0] {
        ENT_CMD   = 2'b00,
        ENT_DATA  = 2'b01,
        ENT_DELAY = 2'b10,
        ENT_END   = 2'b11
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_DELAY,
        ST_FINISH
    } state_t;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    function automatic longint max2(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    // Number of bits needed to hold the value v.
    function automatic int bits_for(input longint v);
        for (int i = 1; i < 63; i++) begin
            if ((longint'(1) << i) > v) return i;
        end
        return 63;
    endfunction

endpackage

// File: rtl/spi_tx_byte.sv
// Write-only SPI (mode 0) byte serializer driving CS, D/C, SCLK and MOSI.
// Latency: CS falls the cycle after send; frame is (2*DW+2)*CLK_DIV cycles.
// Backpressure: send is only taken while tx_busy is low; tx_done marks the last CS-low cycle.
//
// Ports: clk, rst (async active-low); send/dc_in/byte_in start a frame;
// tx_done pulses in the final CS-low cycle (CS rises at the edge that ends it),
// tx_busy is high for the whole frame; cs_n/dc/sclk/mosi go to the panel.
module spi_tx_byte #(
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic          dc_in,
    input  logic [DW-1:0] byte_in,
    output logic          tx_done,
    output logic          tx_busy,
    output logic          cs_n,
    output logic          dc,
    output logic          sclk,
    output logic          mosi
);

    // Frame = 2*DW+2 half-periods: a low setup half, DW high/low SCLK pairs,
    // and a trailing low hold half before CS is released.
    localparam int HALVES = 2 * DW + 2;
    localparam int HW     = $clog2(HALVES);
    localparam int DVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic           active;
    logic [DVW-1:0] div;
    logic [HW-1:0]  half;
    logic [HW-1:0]  half_n;
    logic [DW-1:0]  shreg;
    logic           half_end;

    assign half_n   = half + HW'(1);
    assign half_end = active && (div == DVW'(CLK_DIV - 1));
    assign tx_done  = half_end && (half == HW'(HALVES - 1));
    assign tx_busy  = active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            div    <= '0;
            half   <= '0;
            shreg  <= '0;
            cs_n   <= 1'b1;
            dc     <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
        end else if (!active) begin
            if (send) begin
                active <= 1'b1;
                cs_n   <= 1'b0;
                dc     <= dc_in;
                shreg  <= byte_in;
                mosi   <= byte_in[DW-1];
                div    <= '0;
                half   <= '0;
                sclk   <= 1'b0;
            end
        end else if (!half_end) begin
            div <= div + DVW'(1);
        end else begin
            div <= '0;
            if (tx_done) begin
                active <= 1'b0;
                cs_n   <= 1'b1;
                mosi   <= 1'b0;
                half   <= '0;
            end else begin
                half <= half_n;
                // Odd halves below 2*DW are the SCLK high phases.
                sclk <= half_n[0] && (half_n < HW'(2 * DW));
                // Advance MOSI only on falling edges that still have a bit to follow,
                // so the last bit is held through its high phase and the hold half.
                if (!half_n[0] && (half_n < HW'(2 * DW))) begin
                    shreg <= shreg << 1;
                    mosi  <= shreg[DW-2];
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: reset pulse, wake wait, then replays a command ROM over SPI.
// Latency: first CS fall 1+RST_LOW_CYC+RST_WAIT_CYC+2 cycles after start; 2 cycles fetch/decode per entry.
// Backpressure: start is ignored while busy; SPI bus belongs to downstream only once done is high.
//
// Ports: clk, rst (async active-low), start (1-cycle pulse); rom_addr/rom_data
// form a 1-cycle-latency ROM read port with words {type[1:0], payload[DW-1:0]};
// lcd_rst_n/lcd_cs_n/lcd_dc/lcd_sclk/lcd_mosi drive the panel; busy, done report progress.
module ili9341_init_seq
    import ili9341_pkg::*;
#(
    parameter int DW           = 8,
    parameter int AW           = 6,
    parameter int CLK_DIV      = 4,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 1_500_000,
    parameter int DLY_UNIT     = 100_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [DW+1:0] rom_data,
    output logic          lcd_rst_n,
    output logic          lcd_cs_n,
    output logic          lcd_dc,
    output logic          lcd_sclk,
    output logic          lcd_mosi,
    output logic          busy,
    output logic          done
);

    // One down-counter serves the reset pulse, the wake wait and DELAY entries.
    localparam longint CNT_MAX = max2(max2(longint'(RST_WAIT_CYC), longint'(RST_LOW_CYC)),
                                      longint'(255) * longint'(DLY_UNIT));
    localparam int     CW      = bits_for(CNT_MAX);
    typedef logic [CW-1:0] cnt_t;

    state_t        state, state_nxt;
    cnt_t          cnt, cnt_nxt;
    logic [AW-1:0] addr_nxt;
    logic          busy_nxt, done_nxt;

    entry_t        ent;
    logic [DW-1:0] payload;
    logic          addr_last;
    state_t        adv_state;
    logic [AW-1:0] adv_addr;

    logic          send;
    logic          tx_done;
    logic          tx_busy;

    assign ent       = entry_t'(rom_data[DW+1:DW]);
    assign payload   = rom_data[DW-1:0];
    // Stepping past the last ROM slot would wrap to 0; finish instead.
    assign addr_last = &rom_addr;
    assign adv_state = addr_last ? ST_FINISH : ST_FETCH;
    assign adv_addr  = addr_last ? rom_addr : rom_addr + AW'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - cnt_t'(1) : cnt;
        addr_nxt  = rom_addr;
        busy_nxt  = busy;
        done_nxt  = done;
        send      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RST_LOW;
                    cnt_nxt   = cnt_t'(RST_LOW_CYC - 1);
                    addr_nxt  = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                end
            end
            ST_RST_LOW: begin
                if (cnt == '0) begin
                    state_nxt = ST_RST_WAIT;
                    cnt_nxt   = cnt_t'(RST_WAIT_CYC - 1);
                end
            end
            ST_RST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_FETCH;
                    addr_nxt  = '0;
                end
            end
            ST_FETCH: state_nxt = ST_DECODE;
            ST_DECODE: begin
                // rom_data is valid here: the address was held through FETCH.
                case (ent)
                    ENT_CMD, ENT_DATA: begin
                        if (!tx_busy) begin
                            send      = 1'b1;
                            state_nxt = ST_SEND;
                        end
                    end
                    ENT_DELAY: begin
                        if (payload == '0) begin
                            state_nxt = adv_state;
                            addr_nxt  = adv_addr;
                        end else begin
                            cnt_nxt   = cnt_t'(payload) * cnt_t'(DLY_UNIT) - cnt_t'(1);
                            state_nxt = ST_DELAY;
                        end
                    end
                    default: state_nxt = ST_FINISH;
                endcase
            end
            ST_SEND: begin
                // tx_done is the final CS-low cycle, so FETCH lines up with CS rising.
                if (tx_done) begin
                    state_nxt = adv_state;
                    addr_nxt  = adv_addr;
                end
            end
            ST_DELAY: begin
                if (cnt == '0) begin
                    state_nxt = adv_state;
                    addr_nxt  = adv_addr;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lcd_rst_n <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rom_addr  <= addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            // Registered so RESX is low exactly for the cycles spent in RST_LOW.
            lcd_rst_n <= (state_nxt != ST_RST_LOW);
        end
    end

    spi_tx_byte #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .send    (send),
        .dc_in   (ent == ENT_DATA),
        .byte_in (payload),
        .tx_done (tx_done),
        .tx_busy (tx_busy),
        .cs_n    (lcd_cs_n),
        .dc      (lcd_dc),
        .sclk    (lcd_sclk),
        .mosi    (lcd_mosi)
    );

endmodule

// File: tb/tb_ili9341_init_seq.sv
// Table-driven bench for ili9341_init_seq with a 1-cycle ROM model and an SPI frame monitor.
module tb_ili9341_init_seq;
    import ili9341_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DIV   = 4;
    localparam int LOWC  = 5;
    localparam int WAITC = 20;
    localparam int UNIT  = 10;
    localparam int FRAME = (2 * DW + 2) * DIV;      // 72
    localparam int FIRST = 1 + LOWC + WAITC + 2;    // start cycle to first CS fall

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW+1:0] rom_data = '0;
    logic          lcd_rst_n, lcd_cs_n, lcd_dc, lcd_sclk, lcd_mosi, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW+1:0] rom [4];
    always @(posedge clk) rom_data <= rom[rom_addr];

    ili9341_init_seq #(
        .DW(DW), .AW(AW), .CLK_DIV(DIV),
        .RST_LOW_CYC(LOWC), .RST_WAIT_CYC(WAITC), .DLY_UNIT(UNIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .lcd_rst_n(lcd_rst_n), .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc),
        .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi),
        .busy(busy), .done(done)
    );

    // ---------------- frame monitor ----------------
    typedef struct {
        int         fall;
        int         rise;
        logic [7:0] b;
        logic       d;
        int         nbits;
        bit         dc_ok;
    } frame_t;

    frame_t frames[$];
    int     nstarts = 0;
    int     rst_low_cnt = 0;
    int     rst_fall_cyc = -1;

    initial begin
        frame_t cur;
        bit     in_fr;
        logic   sclk_prev;
        logic   rprev;
        in_fr = 0; sclk_prev = 0; rprev = 1;
        cur = '{0, 0, 8'h00, 1'b0, 0, 1'b1};
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_fr = 0;
            end else begin
                if (!lcd_rst_n) rst_low_cnt++;
                if (rprev && !lcd_rst_n) rst_fall_cyc = cyc;
                if (!in_fr && !lcd_cs_n) begin
                    in_fr = 1;
                    cur = '{cyc, 0, 8'h00, lcd_dc, 0, 1'b1};
                    nstarts++;
                end else if (in_fr && lcd_cs_n) begin
                    in_fr = 0;
                    cur.rise = cyc;
                    frames.push_back(cur);
                end
                if (in_fr) begin
                    if (lcd_dc !== cur.d) cur.dc_ok = 0;
                    if (lcd_sclk && !sclk_prev) begin
                        cur.b = {cur.b[6:0], lcd_mosi};
                        cur.nbits++;
                    end
                end
            end
            sclk_prev = lcd_sclk;
            rprev = lcd_rst_n;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [3:0][DW+1:0] rom;
        int                 nfr;
        logic [3:0][7:0]    b;
        logic [3:0]         d;
        logic [2:0][7:0]    gap;   // CS rise of frame i to CS fall of frame i+1
    } vec_t;

    function automatic logic [DW+1:0] ent(input entry_t t, input logic [7:0] p);
        return {t, p};
    endfunction

    function automatic vec_t mk(input logic [DW+1:0] r0, r1, r2, r3, input int nfr,
                                input logic [7:0] b0, b1, b2, b3, input logic [3:0] d,
                                input logic [7:0] g0, g1, g2);
        vec_t v;
        v.rom[0] = r0; v.rom[1] = r1; v.rom[2] = r2; v.rom[3] = r3;
        v.nfr = nfr;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.d = d;
        v.gap[0] = g0; v.gap[1] = g1; v.gap[2] = g2;
        return v;
    endfunction

    // Runs one sequence from start to done; pulse2 > 0 re-pulses start that many cycles later.
    task automatic run_vec(input vec_t v, input int tag, input int pulse2);
        int fb, sb, rb, k, n;
        bit ok;
        for (int i = 0; i < 4; i++) rom[i] = v.rom[i];
        @(negedge clk);
        fb = frames.size(); sb = nstarts; rb = rst_low_cnt;
        start = 1'b1;
        k = cyc;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", tag), busy, 1);
        chk($sformatf("v%0d_done_cleared", tag), done, 0);
        n = 0; ok = 0;
        while (n < 3000 && !ok) begin
            start = (pulse2 > 0 && n == pulse2);
            @(negedge clk);
            n++;
            ok = done;
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_within_budget", tag), ok, 1);
        repeat (20) @(negedge clk);
        chk($sformatf("v%0d_rst_low_cycles", tag), rst_low_cnt - rb, LOWC);
        chk($sformatf("v%0d_rst_fall_offset", tag), rst_fall_cyc - k, 1);
        chk($sformatf("v%0d_frame_count", tag), nstarts - sb, v.nfr);
        if (frames.size() > fb)
            chk($sformatf("v%0d_start_to_cs_fall", tag), frames[fb].fall - k, FIRST);
        for (int i = 0; i < v.nfr && fb + i < frames.size(); i++) begin
            chk($sformatf("v%0d_f%0d_byte", tag, i), frames[fb+i].b, v.b[i]);
            chk($sformatf("v%0d_f%0d_dc", tag, i), frames[fb+i].d, v.d[i]);
            chk($sformatf("v%0d_f%0d_len", tag, i), frames[fb+i].rise - frames[fb+i].fall, FRAME);
            chk($sformatf("v%0d_f%0d_nbits", tag, i), frames[fb+i].nbits, DW);
            chk($sformatf("v%0d_f%0d_dc_stable", tag, i), frames[fb+i].dc_ok, 1);
        end
        for (int i = 0; i + 1 < v.nfr && fb + i + 1 < frames.size(); i++)
            chk($sformatf("v%0d_gap%0d", tag, i), frames[fb+i+1].fall - frames[fb+i].rise, v.gap[i]);
        chk($sformatf("v%0d_done_final", tag), done, 1);
        chk($sformatf("v%0d_busy_final", tag), busy, 0);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs[5];
        int   n, sb;
        bit   ok;

        vecs[0] = mk(ent(ENT_CMD, CMD_SWRESET), ent(ENT_END, 8'h00), ent(ENT_END, 8'h00), ent(ENT_END, 8'h00),
                     1, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0, 8'd0, 8'd0);
        vecs[1] = mk(ent(ENT_CMD, CMD_COLMOD), ent(ENT_DATA, 8'h55), ent(ENT_END, 8'h00), ent(ENT_END, 8'h00),
                     2, 8'h3A, 8'h55, 8'h00, 8'h00, 4'b0010, 8'd2, 8'd0, 8'd0);
        vecs[2] = mk(ent(ENT_CMD, CMD_SLPOUT), ent(ENT_DELAY, 8'd5), ent(ENT_CMD, CMD_DISPON), ent(ENT_END, 8'h00),
                     2, 8'h11, 8'h29, 8'h00, 8'h00, 4'b0000, 8'd54, 8'd0, 8'd0);
        vecs[3] = mk(ent(ENT_CMD, CMD_MADCTL), ent(ENT_CMD, CMD_COLMOD), ent(ENT_CMD, CMD_DISPON), ent(ENT_CMD, CMD_SLPOUT),
                     4, 8'h36, 8'h3A, 8'h29, 8'h11, 4'b0000, 8'd2, 8'd2, 8'd2);
        vecs[4] = mk(ent(ENT_DATA, 8'hAA), ent(ENT_DELAY, 8'd0), ent(ENT_CMD, CMD_SWRESET), ent(ENT_END, 8'h00),
                     2, 8'hAA, 8'h01, 8'h00, 8'h00, 4'b0001, 8'd4, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) rom[i] = '0;

        // Reset values
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_lcd_rst_n", lcd_rst_n, 1);
        chk("rst_cs_n", lcd_cs_n, 1);
        chk("rst_dc", lcd_dc, 0);
        chk("rst_sclk", lcd_sclk, 0);
        chk("rst_mosi", lcd_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(vecs[v], v, 0);

        // Second start during RST_WAIT must not restart anything
        run_vec(vecs[0], 10, 9);

        // Reset at frame cycle 30 (SCLK high phase)
        for (int i = 0; i < 4; i++) rom[i] = vecs[0].rom[i];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; ok = 0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            n++;
            ok = !lcd_cs_n;
        end
        chk("midrst_frame_started", ok, 1);
        repeat (30) @(negedge clk);
        chk("midrst_sclk_high_before", lcd_sclk, 1);
        rst = 1'b0;
        #1;
        chk("midrst_cs_n", lcd_cs_n, 1);
        chk("midrst_sclk", lcd_sclk, 0);
        chk("midrst_mosi", lcd_mosi, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        sb = nstarts;
        repeat (40) @(negedge clk);
        chk("midrst_idle_no_frame", nstarts - sb, 0);
        chk("midrst_idle_rst_n", lcd_rst_n, 1);
        run_vec(vecs[0], 11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
